// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv - programmable integer clock divider
// Divides CLK by N = R+1 with a near-50% duty Z, a terminal-count pulse and glitch-free ratio reload at wrap.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LD,
  output logic             Z,
  output logic             ZN,
  output logic             TC,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ratio;
  logic [WIDTH-1:0] r_pend;
  logic             r_busy;
  logic             r_z;
  logic             r_zn;
  logic             r_tc;

  logic             w_wrap;
  logic [WIDTH:0]   w_high_len;
  logic             w_z_next;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_clamped;

  // High phase spans counts 0..(R>>1), i.e. ceil(N/2) cycles; extra bit avoids overflow at R = 2^WIDTH-1.
  assign w_wrap        = (r_cnt == r_ratio);
  assign w_high_len    = {1'b0, (r_ratio >> 1)} + {{WIDTH{1'b0}}, 1'b1};
  assign w_z_next      = ({1'b0, r_cnt} < w_high_len);
  assign w_cnt_next    = w_wrap ? '0 : (r_cnt + L_ONE);
  assign w_div_clamped = (DIV == '0) ? L_ONE : DIV;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_ratio <= L_ONE;
      r_pend  <= L_ONE;
      r_busy  <= 1'b0;
      r_z     <= 1'b0;
      r_zn    <= 1'b1;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= EN & w_wrap;
      if (EN) begin
        r_cnt <= w_cnt_next;
        r_z   <= w_z_next;
        r_zn  <= ~w_z_next;
      end
      // A fresh load wins over a coincident wrap, so the previous pending ratio is discarded.
      if (LD) begin
        r_pend <= w_div_clamped;
        r_busy <= 1'b1;
      end else if (EN && w_wrap && r_busy) begin
        r_ratio <= r_pend;
        r_busy  <= 1'b0;
      end
    end
  end

  assign Z    = r_z;
  assign ZN   = r_zn;
  assign TC   = r_tc;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv - self-checking bench for the programmable divider
// Directed vector table, a divide-by-16 sequence, then random stimulus against a period-level model.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [3:0] DIV;
  logic       LD;
  logic       Z;
  logic       ZN;
  logic       TC;
  logic       BUSY;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .DIV  (DIV),
    .LD   (LD),
    .Z    (Z),
    .ZN   (ZN),
    .TC   (TC),
    .BUSY (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit       rst;
    bit       en;
    bit       ld;
    bit [3:0] div;
    bit       z;
    bit       tc;
    bit       busy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Period-level reference: position within the period and the ratio N itself.
  int m_pos, m_n, m_pn;
  bit m_pend, m_z, m_tc;

  task automatic add(input bit rst, input bit en, input bit ld, input int div,
                     input bit z, input bit tc, input bit busy);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.div = 4'(div);
    v.z = z; v.tc = tc; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit ld, input bit [3:0] div);
    RST = rst; EN = en; LD = ld; DIV = div;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit ld, input int div);
    bit last;
    if (rst) begin
      m_pos = 0; m_n = 2; m_pn = 2; m_pend = 0; m_z = 0; m_tc = 0;
    end else begin
      last = (m_pos == m_n - 1);
      m_tc = en && last;
      if (en) begin
        m_z   = (m_pos < (m_n + 1) / 2);
        m_pos = last ? 0 : m_pos + 1;
      end
      if (ld) begin
        m_pn   = ((div == 0) ? 1 : div) + 1;
        m_pend = 1;
      end else if (en && last && m_pend) begin
        m_n    = m_pn;
        m_pend = 0;
      end
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LD = 1'b0; DIV = 4'd0;

    // reset, then default N=2
    add(1,0,0,0, 0,0,0);
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,1,0);
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,1,0);
    // mid-period load DIV=4 at CNT=0, applied at next wrap
    add(0,1,1,4, 1,0,1); add(0,1,0,0, 0,1,0);
    for (int k = 0; k < 2; k++) begin
      add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0);
      add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);
    end
    // enable freeze during the high phase of N=5
    add(0,1,0,0, 1,0,0);
    add(0,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0); add(0,0,0,0, 1,0,0);
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);
    // load DIV=2 coincident with wrap: N=5 runs one more period
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 0,0,0); add(0,1,1,2, 0,1,1);
    add(0,1,0,0, 1,0,1); add(0,1,0,0, 1,0,1); add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 0,0,1); add(0,1,0,0, 0,1,0);
    for (int k = 0; k < 2; k++) begin
      add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,1,0);
    end
    // two loads while busy: only DIV=3 (N=4) takes effect
    add(0,1,1,6, 1,0,1); add(0,1,1,3, 1,0,1); add(0,1,0,0, 0,1,0);
    for (int k = 0; k < 2; k++) begin
      add(0,1,0,0, 1,0,0); add(0,1,0,0, 1,0,0);
      add(0,1,0,0, 0,0,0); add(0,1,0,0, 0,1,0);
    end
    // reset mid-operation with BUSY=1 and Z=1, beating EN and LD
    add(0,1,1,9, 1,0,1); add(1,1,1,5, 0,0,0);
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,1,0); add(0,1,0,0, 1,0,0);
    // DIV=0 clamps to N=2
    add(0,1,1,0, 0,1,1); add(0,1,0,0, 1,0,1); add(0,1,0,0, 0,1,0);
    add(0,1,0,0, 1,0,0); add(0,1,0,0, 0,1,0);
    // DIV=15 load, applied at the following wrap
    add(0,1,1,15, 1,0,1); add(0,1,0,0, 0,1,0);

    @(posedge CLK); #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].div);
      check("tbl_z",    i, Z,    tbl[i].z);
      check("tbl_zn",   i, ZN,   !tbl[i].z);
      check("tbl_tc",   i, TC,   tbl[i].tc);
      check("tbl_busy", i, BUSY, tbl[i].busy);
    end

    // N=16: eight high, eight low, TC on the sixteenth cycle
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, 0);
      check("n16_z",  i, Z,  ((i % 16) < 8) ? 1 : 0);
      check("n16_tc", i, TC, ((i % 16) == 15) ? 1 : 0);
    end

    // randomized run against the reference model
    drive(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit       r, e, l;
      bit [3:0] d;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 19) == 0);
      d = 4'($urandom_range(0, 15));
      drive(r, e, l, d);
      model_step(r, e, l, int'(d));
      check("rnd_z",    i, Z,    m_z);
      check("rnd_zn",   i, ZN,   !m_z);
      check("rnd_tc",   i, TC,   m_tc);
      check("rnd_busy", i, BUSY, m_pend);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
